// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and helpers for the buffered 1:4 demux
package demux_pkg;

    localparam int NUM_CH = 4;

    // Select codes as seen on {x,y}; values mirror the MUXmulti mapping.
    typedef enum logic [1:0] {
        CH_A = 2'b00,
        CH_C = 2'b01,
        CH_B = 2'b10,
        CH_D = 2'b11
    } chan_e;

    function automatic logic [1:0] xy_to_idx(input logic x, input logic y);
        chan_e code;
        code = chan_e'({x, y});
        case (code)
            CH_A:    return 2'd0;
            CH_B:    return 2'd1;
            CH_C:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// rtl/demux_chan_fifo.sv - per-channel FIFO with wrap-bit pointers
module demux_chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Guards keep the pointers sane even if a caller ignores full/empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is masked while empty so drained or reset channels never show stale beats.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/demux_1to4_buf.sv
// rtl/demux_1to4_buf.sv - buffered 1:4 stream demux, explicit or round-robin routing
module demux_1to4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          x,
    input  logic                          y,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_CH-1:0][WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0]             out_valid,
    input  logic [NUM_CH-1:0]             out_ready
);

    logic [1:0]        rr_ptr;
    logic [1:0]        target;
    logic              accept;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    assign target   = mode ? rr_ptr : xy_to_idx(x, y);
    // Registered full only: a same-cycle pop does not open space for a push.
    assign in_ready = !full[target];
    assign accept   = in_valid && in_ready;

    // Pointer parks at a outside round-robin so every RR session starts at a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (!mode) begin
            rr_ptr <= 2'd0;
        end else if (accept) begin
            rr_ptr <= rr_next(rr_ptr);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign push[i]      = accept && (target == 2'(i));
        assign pop[i]       = out_valid[i] && out_ready[i];
        assign out_valid[i] = !empty[i];

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (in_data),
            .pop       (pop[i]),
            .head      (out_data[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// tb/tb_demux_1to4_buf.sv - directed self-checking bench for demux_1to4_buf
module tb_demux_1to4_buf;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic            x;
    logic            y;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;

    int checks = 0;
    int errors = 0;

    demux_1to4_buf #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Reset held for three cycles
        tick(); tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Explicit routing: 00->a, 10->b, 01->c, 11->d
        out_ready = 4'b1111;
        begin
            logic [7:0] dat [4];
            logic [1:0] xy  [4];
            int         idx [4];
            dat = '{8'h11, 8'h22, 8'h33, 8'h44};
            xy  = '{2'b00, 2'b10, 2'b01, 2'b11};
            idx = '{0, 1, 2, 3};
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = dat[k];
                {x, y}   = xy[k];
                #1;
                check("exp_in_ready", 32'(in_ready), 32'h1);
                tick();
                in_valid = 1'b0;
                #1;
                check("exp_valid_onehot", 32'(out_valid), 32'(4'b0001 << idx[k]));
                check("exp_data", 32'(out_data[idx[k]]), 32'(dat[k]));
                tick();
                check("exp_drained", 32'(out_valid), 32'h0);
            end
        end

        // Backpressure on a: two beats fit, third refused, b unaffected
        out_ready = 4'b1110;
        {x, y} = 2'b00;
        in_valid = 1'b1;
        in_data = 8'h51; #1; check("bp_rdy1", 32'(in_ready), 32'h1); tick();
        in_data = 8'h52; #1; check("bp_rdy2", 32'(in_ready), 32'h1); tick();
        in_data = 8'h53; #1; check("bp_rdy3_full", 32'(in_ready), 32'h0); tick();
        check("bp_a_head", 32'(out_data[0]), 32'h51);
        {x, y} = 2'b10;
        in_data = 8'h61; #1; check("bp_b_ready", 32'(in_ready), 32'h1); tick();
        in_valid = 1'b0; #1;
        check("bp_b_valid", 32'(out_valid), 32'b0011);
        check("bp_b_data", 32'(out_data[1]), 32'h61);
        tick();
        // Full FIFO popping this cycle must still refuse the push
        out_ready = 4'b1111;
        {x, y} = 2'b00;
        in_valid = 1'b1;
        in_data = 8'h53; #1;
        check("full_pop_refuse", 32'(in_ready), 32'h0);
        check("drain_a0", 32'(out_data[0]), 32'h51);
        tick();
        in_valid = 1'b0; #1;
        check("drain_a1", 32'(out_data[0]), 32'h52);
        check("drain_a1_valid", 32'(out_valid), 32'b0001);
        tick();
        check("drain_a_empty", 32'(out_valid), 32'h0);

        // Round-robin, x/y randomised and ignored
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(k);
            x = 1'($urandom);
            y = 1'($urandom);
            #1;
            check("rr_ready", 32'(in_ready), 32'h1);
            tick();
            #1;
            check("rr_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
            check("rr_data", 32'(out_data[k % 4]), 32'(8'hA0 + 8'(k)));
        end
        in_valid = 1'b0;
        tick();

        // RR stall at c: ten beats fill c (B2,B6), then the stream blocks on c
        out_ready = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(k);
            #1;
            check("rrs_ready", 32'(in_ready), 32'h1);
            tick();
        end
        in_data = 8'hBA;
        #1;
        check("rrs_block", 32'(in_ready), 32'h0);
        tick();
        x = 1'b1; y = 1'b1; #1;
        check("rrs_hold", 32'(in_ready), 32'h0);
        check("rrs_c_head", 32'(out_data[2]), 32'hB2);
        out_ready = 4'b1111; #1;
        check("rrs_full_reg", 32'(in_ready), 32'h0);
        tick();
        check("rrs_resume_rdy", 32'(in_ready), 32'h1);
        check("rrs_c_head2", 32'(out_data[2]), 32'hB6);
        tick();
        in_valid = 1'b0; #1;
        check("rrs_c_new", 32'(out_data[2]), 32'hBA);
        check("rrs_c_valid", 32'(out_valid), 32'b0100);
        tick();
        in_valid = 1'b1;
        in_data  = 8'hBB;
        tick();
        in_valid = 1'b0; #1;
        check("rrs_next_d", 32'(out_valid), 32'b1000);
        check("rrs_next_d_data", 32'(out_data[3]), 32'hBB);
        tick();

        // Mid-operation asynchronous reset
        mode = 1'b0;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        {x, y} = 2'b00; in_data = 8'hC1; tick();
        {x, y} = 2'b11; in_data = 8'hC2; tick();
        in_valid = 1'b0; #1;
        check("mid_filled", 32'(out_valid), 32'b1001);
        rst_n = 1'b0; #1;
        check("mid_async_valid", 32'(out_valid), 32'h0);
        check("mid_async_data", 32'(out_data), 32'h0);
        check("mid_async_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_mid_valid", 32'(out_valid), 32'h0);
        check("post_mid_data", 32'(out_data), 32'h0);
        mode = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hD0;
        x = 1'b1; y = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        check("post_mid_rr_a", 32'(out_valid), 32'b0001);
        check("post_mid_rr_data", 32'(out_data[0]), 32'hD0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
